write_back_stage: RTL and testbench

- Registered, parametrised write-back stage between the memory stage and the register file / PC.
- Accepts completed results through a valid/ready handshake and buffers them in a 2-entry FIFO (head plus skid), so the upstream ready never depends on register-file back-pressure in the same cycle.
- Commits rd and PC writes in program order, suppresses x0 writes, exposes forwarding data for pending entries, counts retired instructions, and supports flush plus halt/resume.

---
 rtl/write_back_stage.sv | 139 +++++++++++++
 tb/tb_write_back_stage.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/write_back_stage.sv
// Write-back stage: 2-entry in-order buffer (head + skid) feeding the
// register file and PC. Commits in program order, hides x0 writes,
// forwards pending results, counts retirements, supports halt/resume/flush.
module write_back_stage #(
  parameter int XLEN      = 32,
  parameter int REG_IDX_W = 5,
  parameter int INSTRET_W = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [REG_IDX_W-1:0] in_rd_index,
  input  logic [XLEN-1:0]      in_result,
  input  logic [XLEN-1:0]      in_pc_next,
  input  logic                 in_need_write_rd,
  input  logic                 in_halt,
  input  logic                 flush,
  input  logic                 resume,
  input  logic                 rf_ready,
  output logic [REG_IDX_W-1:0] rd_write_index,
  output logic [XLEN-1:0]      rd_write_data,
  output logic                 rd_write_enable,
  output logic [XLEN-1:0]      pc_write_data,
  output logic                 pc_write_enable,
  output logic                 fwd0_valid,
  output logic [REG_IDX_W-1:0] fwd0_index,
  output logic [XLEN-1:0]      fwd0_data,
  output logic                 fwd1_valid,
  output logic [REG_IDX_W-1:0] fwd1_index,
  output logic [XLEN-1:0]      fwd1_data,
  output logic                 halted,
  output logic [INSTRET_W-1:0] instret
);

  localparam logic [0:0] S_RUN    = 1'b0;
  localparam logic [0:0] S_HALTED = 1'b1;

  // Slot 0 is always the head (oldest), slot 1 the skid (youngest).
  logic [1:0]                r_count;
  logic [0:0]                r_state;
  logic [INSTRET_W-1:0]      r_instret;
  logic [1:0][REG_IDX_W-1:0] r_idx;
  logic [1:0][XLEN-1:0]      r_res;
  logic [1:0][XLEN-1:0]      r_pc;
  logic [1:0]                r_wr;
  logic [1:0]                r_halt;

  logic w_head_vld;
  logic w_skid_vld;
  logic w_push;
  logic w_commit;
  logic w_head_wr;
  logic w_skid_wr;

  assign w_head_vld = (r_count != 2'd0);
  assign w_skid_vld = (r_count == 2'd2);
  // rst only gates these so nothing is accepted or strobed in a reset cycle.
  assign in_ready   = !rst && (r_count != 2'd2);
  assign w_push     = in_valid && in_ready && !flush;
  assign w_commit   = !rst && w_head_vld && rf_ready && (r_state == S_RUN) && !flush;

  assign w_head_wr  = r_wr[0] && (r_idx[0] != '0);
  assign w_skid_wr  = r_wr[1] && (r_idx[1] != '0);

  assign rd_write_index  = r_idx[0];
  assign rd_write_data   = r_res[0];
  assign rd_write_enable = w_commit && w_head_wr;
  assign pc_write_data   = r_pc[0];
  assign pc_write_enable = w_commit;

  assign fwd0_valid = !rst && w_head_vld && w_head_wr;
  assign fwd0_index = r_idx[0];
  assign fwd0_data  = r_res[0];
  assign fwd1_valid = !rst && w_skid_vld && w_skid_wr;
  assign fwd1_index = r_idx[1];
  assign fwd1_data  = r_res[1];

  assign halted  = (r_state == S_HALTED);
  assign instret = r_instret;

  // Entry payload: shift skid into head on pop, land pushes in the first free slot.
  always_ff @(posedge clk) begin
    if (!rst && !flush) begin
      if (w_commit) begin
        if (w_push) begin
          // Only possible with count==1: the new entry becomes head directly.
          r_idx[0]  <= in_rd_index;
          r_res[0]  <= in_result;
          r_pc[0]   <= in_pc_next;
          r_wr[0]   <= in_need_write_rd;
          r_halt[0] <= in_halt;
        end else begin
          r_idx[0]  <= r_idx[1];
          r_res[0]  <= r_res[1];
          r_pc[0]   <= r_pc[1];
          r_wr[0]   <= r_wr[1];
          r_halt[0] <= r_halt[1];
        end
      end else if (w_push) begin
        r_idx[r_count[0]]  <= in_rd_index;
        r_res[r_count[0]]  <= in_result;
        r_pc[r_count[0]]   <= in_pc_next;
        r_wr[r_count[0]]   <= in_need_write_rd;
        r_halt[r_count[0]] <= in_halt;
      end
    end
  end

  // Occupancy, run/halt state and retirement counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count   <= 2'd0;
      r_state   <= S_RUN;
      r_instret <= '0;
    end else begin
      if (flush) begin
        r_count <= 2'd0;
      end else begin
        case ({w_push, w_commit})
          2'b10:   r_count <= r_count + 2'd1;
          2'b01:   r_count <= r_count - 2'd1;
          default: r_count <= r_count;
        endcase
      end
      if (w_commit) begin
        r_instret <= r_instret + INSTRET_W'(1);
      end
      if (r_state == S_RUN) begin
        if (w_commit && r_halt[0]) begin
          r_state <= S_HALTED;
        end
      end else if (resume) begin
        r_state <= S_RUN;
      end
    end
  end

endmodule

// File: tb/tb_write_back_stage.sv
// Scoreboard bench for write_back_stage: expected commits are queued when an
// entry is accepted and compared when the PC strobe fires.
module tb_write_back_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [4:0]  in_rd_index;
  logic [31:0] in_result, in_pc_next;
  logic        in_need_write_rd, in_halt;
  logic        flush, resume, rf_ready;
  logic [4:0]  rd_write_index;
  logic [31:0] rd_write_data;
  logic        rd_write_enable;
  logic [31:0] pc_write_data;
  logic        pc_write_enable;
  logic        fwd0_valid, fwd1_valid;
  logic [4:0]  fwd0_index, fwd1_index;
  logic [31:0] fwd0_data, fwd1_data;
  logic        halted;
  logic [63:0] instret;

  always #5 clk = ~clk;

  write_back_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rd_index(in_rd_index), .in_result(in_result), .in_pc_next(in_pc_next),
    .in_need_write_rd(in_need_write_rd), .in_halt(in_halt),
    .flush(flush), .resume(resume), .rf_ready(rf_ready),
    .rd_write_index(rd_write_index), .rd_write_data(rd_write_data),
    .rd_write_enable(rd_write_enable),
    .pc_write_data(pc_write_data), .pc_write_enable(pc_write_enable),
    .fwd0_valid(fwd0_valid), .fwd0_index(fwd0_index), .fwd0_data(fwd0_data),
    .fwd1_valid(fwd1_valid), .fwd1_index(fwd1_index), .fwd1_data(fwd1_data),
    .halted(halted), .instret(instret)
  );

  typedef struct {
    logic [4:0]  idx;
    logic [31:0] data;
    logic [31:0] pc;
    logic        wen;
  } exp_t;

  exp_t        sb[$];
  int          n_chk = 0;
  int          n_err = 0;
  logic [63:0] exp_ret = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // Compare any commit visible this cycle against the scoreboard head.
  task automatic mon();
    exp_t e;
    if (pc_write_enable === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexp_commit_pc", pc_write_data, 0);
      end else begin
        e = sb.pop_front();
        chk("commit_pc", pc_write_data, e.pc);
        chk("commit_rd_we", rd_write_enable, e.wen);
        if (e.wen) begin
          chk("commit_rd_idx", rd_write_index, e.idx);
          chk("commit_rd_data", rd_write_data, e.data);
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
  endtask

  // Offer one entry until accepted; exp=1 queues the expected commit.
  task automatic send(input logic [4:0] idx, input logic [31:0] d, input logic [31:0] pc,
                      input logic wr, input logic hlt, input logic exp, output int tries);
    bit acc = 0;
    exp_t e;
    in_valid = 1; in_rd_index = idx; in_result = d; in_pc_next = pc;
    in_need_write_rd = wr; in_halt = hlt;
    tries = 0;
    while (!acc && tries < 20) begin
      @(negedge clk);
      mon();
      if (in_ready) begin
        acc = 1;
        if (exp) begin
          e.idx = idx; e.data = d; e.pc = pc; e.wen = wr && (idx != 0);
          sb.push_back(e);
          exp_ret++;
        end
      end else begin
        tries++;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 0;
    if (!acc) chk("send_timeout", 0, 1);
  endtask

  task automatic drain();
    int n = 0;
    rf_ready = 1;
    while (sb.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    chk("drain_empty", sb.size(), 0);
  endtask

  initial begin
    int t;
    rst = 1; in_valid = 0; in_rd_index = 0; in_result = 0; in_pc_next = 0;
    in_need_write_rd = 0; in_halt = 0; flush = 0; resume = 0; rf_ready = 1;
    @(posedge clk); #1;
    chk("rst_in_ready", in_ready, 0);
    tick(); tick();
    rst = 0; #1;
    chk("rst_count_ready", in_ready, 1);
    chk("rst_halted", halted, 0);
    chk("rst_instret", instret, 0);
    chk("rst_pc_we", pc_write_enable, 0);
    chk("rst_fwd0", fwd0_valid, 0);

    // back-to-back
    send(5'd5, 32'h1234, 32'h8, 1, 0, 1, t);
    chk("b2b_lat_pc_we", pc_write_enable, 1);
    chk("b2b_lat_pc", pc_write_data, 32'h8);
    chk("b2b_lat_rd", rd_write_index, 5);
    send(5'd6, 32'h55, 32'hC, 1, 0, 1, t);
    chk("b2b_ready_stall", t, 0);
    chk("b2b_lat2_pc", pc_write_data, 32'hC);
    tick(); tick();
    chk("b2b_empty", sb.size(), 0);
    chk("b2b_instret", instret, 2);

    // back-pressure
    rf_ready = 0;
    send(5'd7, 32'hA1, 32'h10, 1, 0, 1, t);
    send(5'd8, 32'hA2, 32'h14, 1, 0, 1, t);
    chk("bp_ready", in_ready, 0);
    chk("bp_fwd0_v", fwd0_valid, 1);
    chk("bp_fwd0_i", fwd0_index, 7);
    chk("bp_fwd0_d", fwd0_data, 32'hA1);
    chk("bp_fwd1_v", fwd1_valid, 1);
    chk("bp_fwd1_i", fwd1_index, 8);
    chk("bp_fwd1_d", fwd1_data, 32'hA2);
    in_valid = 1; in_rd_index = 9; in_result = 32'hA3; in_pc_next = 32'h18;
    in_need_write_rd = 1;
    tick(); tick();
    chk("bp_held_ready", in_ready, 0);
    chk("bp_no_commit", pc_write_enable, 0);
    in_valid = 0;
    drain();
    send(5'd9, 32'hA3, 32'h18, 1, 0, 1, t);
    drain();
    chk("bp_instret", instret, exp_ret);

    // x0 write suppressed but still retires
    send(5'd0, 32'hDEAD, 32'h20, 1, 0, 1, t);
    chk("x0_rd_we", rd_write_enable, 0);
    chk("x0_pc_we", pc_write_enable, 1);
    chk("x0_pc", pc_write_data, 32'h20);
    chk("x0_fwd0", fwd0_valid, 0);
    drain();
    chk("x0_instret", instret, exp_ret);

    // halt / resume
    send(5'd10, 32'h77, 32'h40, 1, 1, 1, t);
    send(5'd11, 32'h88, 32'h44, 1, 0, 1, t);
    chk("halt_halted", halted, 1);
    chk("halt_no_commit", pc_write_enable, 0);
    chk("halt_fwd0_i", fwd0_index, 11);
    chk("halt_instret", instret, exp_ret - 1);
    tick(); tick();
    chk("halt_still", halted, 1);
    chk("halt_still_no_we", pc_write_enable, 0);
    resume = 1;
    tick();
    resume = 0;
    chk("resume_halted", halted, 0);
    chk("resume_pc_we", pc_write_enable, 1);
    chk("resume_pc", pc_write_data, 32'h44);
    drain();
    chk("resume_instret", instret, exp_ret);

    // flush with full buffer and a pending input
    rf_ready = 0;
    send(5'd12, 32'h1, 32'h50, 1, 0, 0, t);
    send(5'd13, 32'h2, 32'h54, 1, 0, 0, t);
    rf_ready = 1; flush = 1; in_valid = 1;
    in_rd_index = 14; in_result = 32'h3; in_pc_next = 32'h58; in_need_write_rd = 1;
    #1;
    chk("flush_pc_we", pc_write_enable, 0);
    chk("flush_rd_we", rd_write_enable, 0);
    tick();
    flush = 0; in_valid = 0;
    chk("flush_ready", in_ready, 1);
    chk("flush_fwd0", fwd0_valid, 0);
    // flush with count=1 where the same-cycle push would have been accepted
    rf_ready = 0;
    send(5'd15, 32'h4, 32'h5C, 1, 0, 0, t);
    flush = 1; in_valid = 1; in_rd_index = 16; in_pc_next = 32'h60;
    #1;
    chk("flush1_ready", in_ready, 1);
    tick();
    flush = 0; in_valid = 0; rf_ready = 1;
    chk("flush1_fwd0", fwd0_valid, 0);
    tick(); tick();
    chk("flush_instret", instret, exp_ret);

    // reset mid-operation
    rf_ready = 0;
    send(5'd17, 32'h5, 32'h64, 1, 0, 0, t);
    send(5'd18, 32'h6, 32'h68, 1, 0, 0, t);
    rf_ready = 1; rst = 1;
    #1;
    chk("mrst_pc_we", pc_write_enable, 0);
    chk("mrst_rd_we", rd_write_enable, 0);
    chk("mrst_fwd0", fwd0_valid, 0);
    chk("mrst_fwd1", fwd1_valid, 0);
    chk("mrst_ready", in_ready, 0);
    tick();
    rst = 0; exp_ret = 0;
    #1;
    chk("mrst_post_ready", in_ready, 1);
    chk("mrst_post_instret", instret, exp_ret);
    chk("mrst_post_fwd0", fwd0_valid, 0);
    tick(); tick();
    chk("final_sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
